// File: rtl/mem_arb_if.sv
// Handshake bundle between the two cache requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the caches/memory side.
interface mem_arb_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              grant_d;
  logic              busy;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output grant_d, busy
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  grant_d, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and the D-cache.
//   state   | meaning
//   IDLE    | no owner; arbitrate between pending requests
//   SERVE_I | I-cache owns the port, waiting for mem_ready
//   SERVE_D | D-cache owns the port, waiting for mem_ready
//   RELEASE | one-cycle gap with the memory request dropped
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state;
  logic              last_grant;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic i_req;
  logic d_req;
  logic pick_i;

  assign i_req  = bus.i_read | bus.i_write;
  assign d_req  = bus.d_read | bus.d_write;
  // On a tie the side that did not win last time gets the port.
  assign pick_i = i_req & (~d_req | last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state       <= SERVE_I;
            last_grant  <= 1'b0;
            mem_write_q <= bus.i_write;
            mem_read_q  <= bus.i_read & ~bus.i_write;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= bus.i_wdata;
          end else if (d_req) begin
            state       <= SERVE_D;
            last_grant  <= 1'b1;
            mem_write_q <= bus.d_write;
            mem_read_q  <= bus.d_read & ~bus.d_write;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_ready) begin
            state       <= RELEASE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Completion is combinational so the cache sees ready in the same cycle as mem_ready.
  assign bus.i_ready = (state == SERVE_I) & bus.mem_ready;
  assign bus.d_ready = (state == SERVE_D) & bus.mem_ready;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  assign bus.grant_d = (state == SERVE_D);
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a cycle-count based transaction model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.i_read = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.grant_d, bus.busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got rd=%b wr=%b ir=%b dr=%b gd=%b busy=%b exp all 0",
               bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.grant_d, bus.busy);
    end
    total++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_bus got addr=%h wdata=%h exp 0", bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] pat;
    pat = {16{8'hA5}};
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000010;
    tick();
    total++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000010) begin
      bad++;
      $display("FAIL single_req got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=0000010",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat;
    #1;
    total++;
    if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.i_rdata !== pat) begin
      bad++;
      $display("FAIL single_ready got ir=%b dr=%b rdata=%h exp ir=1 dr=0 rdata=%h",
               bus.i_ready, bus.d_ready, bus.i_rdata, pat);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== '0) begin
      bad++;
      $display("FAIL single_release got busy=%b rd=%b addr=%h exp busy=1 rd=0 addr=0",
               bus.busy, bus.mem_read, bus.mem_addr);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got busy=%b exp 0", bus.busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.i_read  = 1'b1; bus.i_addr  = 28'h40;
    bus.d_write = 1'b1; bus.d_addr  = 28'h20; bus.d_wdata = 128'h1234;
    tick();
    total++;
    if (bus.grant_d !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h40) begin
      bad++;
      $display("FAIL simul_first got gd=%b rd=%b addr=%h exp gd=0 rd=1 addr=40",
               bus.grant_d, bus.mem_read, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h77;
    #1;
    total++;
    if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_iready got ir=%b dr=%b exp ir=1 dr=0", bus.i_ready, bus.d_ready);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read = 1'b0;
    tick();
    tick();
    total++;
    if (bus.grant_d !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
        bus.mem_addr !== 28'h20 || bus.mem_wdata !== 128'h1234) begin
      bad++;
      $display("FAIL simul_second got gd=%b wr=%b rd=%b addr=%h wdata=%h exp gd=1 wr=1 rd=0 addr=20 wdata=1234",
               bus.grant_d, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_dready got dr=%b ir=%b exp dr=1 ir=0", bus.d_ready, bus.i_ready);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.d_write = 1'b0;
    total++;
    if (bus.grant_d !== 1'b0) begin
      bad++;
      $display("FAIL simul_release got gd=%b exp 0", bus.grant_d);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_d;
    int gap;
    do_reset();
    bus.i_read = 1'b1; bus.i_addr = 28'h111;
    bus.d_read = 1'b1; bus.d_addr = 28'h222;
    exp_d = 0;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      while (!(bus.mem_read | bus.mem_write) && gap < 8) begin
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
          bad++;
          $display("FAIL rr_spurious got ir=%b dr=%b exp 0 0", bus.i_ready, bus.d_ready);
        end
        bus.mem_ready = 1'b0;
        tick();
        gap++;
      end
      total++;
      if (gap >= 8 || (k > 0 && gap != 2)) begin
        bad++;
        $display("FAIL rr_gap txn=%0d got idle_cycles=%0d exp 2", k, gap);
      end
      total++;
      if (bus.grant_d !== exp_d[0] || bus.mem_addr !== (exp_d != 0 ? 28'h222 : 28'h111)) begin
        bad++;
        $display("FAIL rr_order txn=%0d got gd=%b addr=%h exp gd=%0d", k, bus.grant_d, bus.mem_addr, exp_d);
      end
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 128'(k + 100);
      #1;
      total++;
      if (bus.d_ready !== exp_d[0] || bus.i_ready !== ~exp_d[0]) begin
        bad++;
        $display("FAIL rr_ready txn=%0d got ir=%b dr=%b exp_d=%0d", k, bus.i_ready, bus.d_ready, exp_d);
      end
      tick();
      bus.mem_ready = 1'b0;
      exp_d = 1 - exp_d;
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_stability();
    bus.i_read = 1'b1; bus.i_addr = 28'h100; bus.i_wdata = '0;
    tick();
    bus.i_addr = 28'h999; bus.i_write = 1'b1; bus.i_wdata = 128'd123;
    tick();
    total++;
    if (bus.mem_addr !== 28'h100 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_wdata !== '0) begin
      bad++;
      $display("FAIL stab_hold got addr=%h wr=%b rd=%b wdata=%h exp addr=100 wr=0 rd=1 wdata=0",
               bus.mem_addr, bus.mem_write, bus.mem_read, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.i_ready !== 1'b1) begin
      bad++;
      $display("FAIL stab_ready got ir=%b exp 1", bus.i_ready);
    end
    tick();
    bus.i_read = 1'b0; bus.i_write = 1'b0;
    #1;
    total++;
    if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
      bad++;
      $display("FAIL stab_release_ignore got ir=%b dr=%b exp 0 0", bus.i_ready, bus.d_ready);
    end
    tick();
    total++;
    if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL stab_idle_ignore got ir=%b dr=%b busy=%b exp 0 0 0", bus.i_ready, bus.d_ready, bus.busy);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 28'h77; bus.d_wdata = 128'd55;
    tick();
    total++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.grant_d !== 1'b1 || bus.mem_wdata !== 128'd55) begin
      bad++;
      $display("FAIL stab_wr_prec got wr=%b rd=%b gd=%b wdata=%h exp wr=1 rd=0 gd=1 wdata=37",
               bus.mem_write, bus.mem_read, bus.grant_d, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1'b1; bus.d_addr = 28'h55;
    tick();
    bus.i_read = 1'b1; bus.i_addr = 28'h66;
    tick();
    total++;
    if (bus.grant_d !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre got gd=%b exp 1", bus.grant_d);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.grant_d, bus.busy, bus.d_ready, bus.i_ready} !== 6'b0 ||
        bus.mem_addr !== '0) begin
      bad++;
      $display("FAIL rmid_async got rd=%b wr=%b gd=%b busy=%b dr=%b ir=%b addr=%h exp all 0",
               bus.mem_read, bus.mem_write, bus.grant_d, bus.busy, bus.d_ready, bus.i_ready, bus.mem_addr);
    end
    tick();
    rst = 1'b0;
    bus.d_read = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.d_ready !== 1'b0 || bus.i_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_no_dready got dr=%b ir=%b exp 0 0", bus.d_ready, bus.i_ready);
    end
    bus.mem_ready = 1'b0;
    tick();
    total++;
    if (bus.grant_d !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h66) begin
      bad++;
      $display("FAIL rmid_next got gd=%b rd=%b addr=%h exp gd=0 rd=1 addr=66",
               bus.grant_d, bus.mem_read, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_iready got ir=%b dr=%b exp 1 0", bus.i_ready, bus.d_ready);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read = 1'b0;
    tick();
    tick();
  endtask

  // Model: a transaction is owned from its grant edge until the edge after mem_ready;
  // the port is then busy one more cycle, and the next grant can happen two edges later.
  task automatic test_random();
    int owner, last, done_at, c;
    bit i_req, d_req, ready_now;
    logic exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [1:0] op;
    do_reset();
    owner = -1; last = 1; done_at = -10; c = 0;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int n = 0; n < 600; n++) begin
      i_req = bus.i_read | bus.i_write;
      d_req = bus.d_read | bus.d_write;
      ready_now = bus.mem_ready;
      tick();
      c++;
      if (owner != -1) begin
        if (ready_now) begin
          if (owner == 0) begin bus.i_read = 1'b0; bus.i_write = 1'b0; end
          else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
          owner = -1;
          done_at = c;
        end
      end else if (c >= done_at + 2 && (i_req || d_req)) begin
        owner = (i_req && d_req) ? (last == 0 ? 1 : 0) : (i_req ? 0 : 1);
        last = owner;
        exp_wr    = (owner == 0) ? bus.i_write : bus.d_write;
        exp_rd    = ((owner == 0) ? bus.i_read : bus.d_read) & ~exp_wr;
        exp_addr  = (owner == 0) ? bus.i_addr : bus.d_addr;
        exp_wdata = (owner == 0) ? bus.i_wdata : bus.d_wdata;
      end
      total++;
      if (bus.mem_read !== (owner != -1 ? exp_rd : 1'b0) ||
          bus.mem_write !== (owner != -1 ? exp_wr : 1'b0) ||
          bus.mem_addr !== (owner != -1 ? exp_addr : '0) ||
          bus.mem_wdata !== (owner != -1 ? exp_wdata : '0) ||
          bus.grant_d !== (owner == 1) ||
          bus.busy !== (owner != -1 || c == done_at)) begin
        bad++;
        $display("FAIL rand_bus cyc=%0d got rd=%b wr=%b addr=%h gd=%b busy=%b exp owner=%0d rd=%b wr=%b addr=%h",
                 c, bus.mem_read, bus.mem_write, bus.mem_addr, bus.grant_d, bus.busy,
                 owner, exp_rd, exp_wr, exp_addr);
      end
      if (!(bus.i_read | bus.i_write) && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(1, 3));
        bus.i_read = op[0]; bus.i_write = op[1];
        bus.i_addr = AW'($urandom);
        bus.i_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!(bus.d_read | bus.d_write) && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(1, 3));
        bus.d_read = op[0]; bus.d_write = op[1];
        bus.d_addr = AW'($urandom);
        bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.mem_ready = (owner != -1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++;
      if (bus.i_ready !== (owner == 0 && bus.mem_ready) || bus.d_ready !== (owner == 1 && bus.mem_ready) ||
          (owner == 0 && bus.mem_ready && bus.i_rdata !== bus.mem_rdata) ||
          (owner == 1 && bus.mem_ready && bus.d_rdata !== bus.mem_rdata)) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d got ir=%b dr=%b exp owner=%0d mem_ready=%b",
                 c, bus.i_ready, bus.d_ready, owner, bus.mem_ready);
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_stability();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, memory block address width (16-byte blocks).
REQ-002 Parameter DATA_W, default 128, memory block data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_read, i_write  in  1 each  I-cache miss/writeback request, held until i_ready.
REQ-006 i_addr  in  ADDR_W  I-cache block address; i_wdata  in  DATA_W  I-cache write data.
REQ-007 i_rdata  out  DATA_W  read data to I-cache; i_ready  out  1  I-cache transaction complete.
REQ-008 d_read, d_write, d_addr, d_wdata  in  same widths and meaning as the I-cache ports, for the D-cache.
REQ-009 d_rdata  out  DATA_W; d_ready  out  1  same meaning as the I-cache ports, for the D-cache.
REQ-010 mem_read, mem_write  out  1 each  request to the shared memory port.
REQ-011 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  request address and data.
REQ-012 mem_rdata  in  DATA_W; mem_ready  in  1  memory completion, one-cycle pulse.
REQ-013 grant_d  out  1  1 = D-cache owns the port (SERVE_D), else 0; busy  out  1  state != IDLE.

Function
REQ-014 FSM states: IDLE, SERVE_I, SERVE_D, RELEASE; state register is the only sequencing state, plus 1-bit last_grant (0=I, 1=D).
REQ-015 Requester X is requesting when X_read | X_write.
REQ-016 IDLE: only I requesting -> SERVE_I; only D requesting -> SERVE_D; neither -> stay in IDLE.
REQ-017 IDLE with both requesting: grant goes to the requester not equal to last_grant (round-robin); last_grant updates on every grant.
REQ-018 On the IDLE->SERVE_X edge, mem_read, mem_write, mem_addr and mem_wdata are registered from requester X.
- If X_write=1, mem_write=1 and mem_read=0; a write takes precedence when both are asserted.
- First memory request is visible exactly 1 cycle after the request is sampled in IDLE.
REQ-019 mem_* outputs are held constant for the whole SERVE_X state, regardless of any change on X inputs.
REQ-020 In SERVE_X with mem_ready=1, X_ready=1 combinationally in the same cycle, X_rdata=mem_rdata, and the next state is RELEASE.
REQ-021 The non-granted requester's ready is 0 at all times; each *_rdata passes mem_rdata through and is valid only while that *_ready=1.
REQ-022 RELEASE lasts exactly one cycle:
- mem_read=mem_write=0, mem_addr/mem_wdata cleared to 0;
- then -> IDLE.
- Minimum back-to-back spacing between two memory requests is therefore 2 idle cycles on mem_read/mem_write.
REQ-023 If a requester drops its request mid-SERVE, the transaction still completes and ready still pulses; the requester ignores it.
REQ-024 mem_ready arriving in IDLE or RELEASE is ignored; no ready output pulses.
REQ-025 A requester whose request is still asserted in the IDLE cycle after RELEASE is re-arbitrated normally under the REQ-017 rule.
REQ-026 Worst-case wait for a held request while the other side requests continuously is one foreign transaction (starvation-free).

Reset
REQ-027 rst=1 forces asynchronously:
- state=IDLE, last_grant=1 (I wins first tie);
- mem_read=mem_write=0, mem_addr=mem_wdata=0;
- i_ready=d_ready=0, grant_d=0, busy=0.
REQ-028 Reset asserted mid-transaction abandons it; no ready pulses for it after reset release, and the first post-reset grant follows REQ-016/017.

Verification
REQ-029 Single I read: i_read=1, i_addr=0x0000010 in IDLE -> next cycle mem_read=1, mem_addr=0x0000010; mem_ready after 3 cycles with mem_rdata=0xA5..A5 -> i_ready=1, i_rdata=0xA5..A5 same cycle; RELEASE, then IDLE.
REQ-030 Simultaneous requests after reset: i_read and d_write (d_addr=0x20, d_wdata=0x1234) both high -> I served first; D served next with mem_write=1, mem_addr=0x20, mem_wdata=0x1234; grant_d=1 only during SERVE_D.
REQ-031 Round-robin under saturation: both requesters always requesting for 6 transactions -> grant order I, D, I, D, I, D; d_ready never asserted while grant_d=0.
REQ-032 Stability/ignore: change i_addr during SERVE_I -> mem_addr unchanged; spurious mem_ready in IDLE -> i_ready=d_ready=0; d_read and d_write both set -> mem_write=1, mem_read=0.
REQ-033 Reset mid-SERVE_D: assert rst for 1 cycle before mem_ready -> all outputs 0 immediately; later mem_ready produces no d_ready; pending i_read is granted next.
